// File: rtl/mem_rmw_pkg.sv
// Shared types and helpers for the read-modify-write SRAM adapter.
package mem_rmw_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RMW_RD = 2'd1,
    RMW_WR = 2'd2
  } state_e;

  function automatic logic [7:0] merge_byte(input logic [7:0] old_byte,
                                            input logic [7:0] new_byte,
                                            input logic       en);
    return en ? new_byte : old_byte;
  endfunction

endpackage

// File: rtl/mem_rmw_adapter_if.sv
// Upstream request/response bus plus SRAM port of the RMW adapter.
interface mem_rmw_adapter_if #(
  parameter int unsigned AddrWidth = 13,
  parameter int unsigned DataWidth = 64
);
  localparam int unsigned StrbWidth = DataWidth / 8;

  logic                 req_i;
  logic                 gnt_o;
  logic                 we_i;
  logic [AddrWidth-1:0] addr_i;
  logic [DataWidth-1:0] wdata_i;
  logic [StrbWidth-1:0] strb_i;
  logic                 rvalid_o;
  logic [DataWidth-1:0] rdata_o;
  logic                 sram_req_o;
  logic                 sram_we_o;
  logic [AddrWidth-1:0] sram_addr_o;
  logic [DataWidth-1:0] sram_wdata_o;
  logic [DataWidth-1:0] sram_rdata_i;
  logic                 busy_o;

  modport slave (
    input  req_i, we_i, addr_i, wdata_i, strb_i, sram_rdata_i,
    output gnt_o, rvalid_o, rdata_o, sram_req_o, sram_we_o, sram_addr_o,
           sram_wdata_o, busy_o
  );

  modport master (
    output req_i, we_i, addr_i, wdata_i, strb_i, sram_rdata_i,
    input  gnt_o, rvalid_o, rdata_o, sram_req_o, sram_we_o, sram_addr_o,
           sram_wdata_o, busy_o
  );

endinterface

// File: rtl/mem_rmw_adapter.sv
// Byte-strobe adapter in front of a full-word SRAM: partial writes become
// a read followed by a merged write; reads and full writes pass straight through.
//   state  | meaning
//   IDLE   | no access in flight, any request accepted
//   RMW_RD | old word arriving from SRAM, merged word written back
//   RMW_WR | partial-write response returned, new request may be accepted
module mem_rmw_adapter #(
  parameter int unsigned AddrWidth = 13,
  parameter int unsigned DataWidth = 64
) (
  input logic               clk_i,
  input logic               rst_i,
  mem_rmw_adapter_if.slave  bus
);
  import mem_rmw_pkg::*;

  localparam int unsigned StrbWidth = DataWidth / 8;

  state_e               state_q, state_d;
  logic [AddrWidth-1:0] addr_q, addr_d;
  logic [DataWidth-1:0] wdata_q, wdata_d;
  logic [StrbWidth-1:0] strb_q, strb_d;
  logic                 rvalid_q, rvalid_d;
  logic                 rsp_rd_q, rsp_rd_d;

  logic                 accept;
  logic                 is_read;
  logic                 is_full;
  logic                 is_zero;
  logic                 is_partial;
  logic                 rvalid;
  logic [DataWidth-1:0] merged;

  always_comb begin
    accept     = bus.req_i && (state_q != RMW_RD) && !rst_i;
    is_read    = !bus.we_i;
    is_full    = bus.we_i && (bus.strb_i == '1);
    is_zero    = bus.we_i && (bus.strb_i == '0);
    is_partial = bus.we_i && !is_full && !is_zero;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      wdata_q  <= '0;
      strb_q   <= '0;
      rvalid_q <= 1'b0;
      rsp_rd_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      strb_q   <= strb_d;
      rvalid_q <= rvalid_d;
      rsp_rd_q <= rsp_rd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, RMW_WR: state_d = (accept && is_partial) ? RMW_RD : IDLE;
      RMW_RD:       state_d = RMW_WR;
      default:      state_d = IDLE;
    endcase
  end

  always_comb begin
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    strb_d   = strb_q;
    if (accept && is_partial) begin
      addr_d  = bus.addr_i;
      wdata_d = bus.wdata_i;
      strb_d  = bus.strb_i;
    end
    // Partial writes answer from RMW_RD, everything else one cycle after grant.
    rvalid_d = (accept && !is_partial) || (state_q == RMW_RD);
    rsp_rd_d = accept && is_read;
  end

  always_comb begin
    merged = '0;
    for (int k = 0; k < int'(StrbWidth); k++) begin
      merged[8*k +: 8] = merge_byte(bus.sram_rdata_i[8*k +: 8], wdata_q[8*k +: 8], strb_q[k]);
    end

    bus.gnt_o        = accept;
    bus.sram_req_o   = 1'b0;
    bus.sram_we_o    = 1'b0;
    bus.sram_addr_o  = '0;
    bus.sram_wdata_o = '0;
    if (!rst_i) begin
      if (state_q == RMW_RD) begin
        bus.sram_req_o   = 1'b1;
        bus.sram_we_o    = 1'b1;
        bus.sram_addr_o  = addr_q;
        bus.sram_wdata_o = merged;
      end else if (accept && !is_zero) begin
        bus.sram_req_o   = 1'b1;
        bus.sram_we_o    = is_full;
        bus.sram_addr_o  = bus.addr_i;
        bus.sram_wdata_o = is_full ? bus.wdata_i : '0;
      end
    end

    rvalid       = rvalid_q && !rst_i;
    bus.rvalid_o = rvalid;
    bus.rdata_o  = (rvalid && rsp_rd_q) ? bus.sram_rdata_i : '0;
    bus.busy_o   = (state_q != IDLE) && !rst_i;
  end

endmodule

// File: tb/tb_mem_rmw_adapter.sv
// Self-checking bench: SRAM model, request-level scoreboard, vector table,
// directed multi-cycle sequences and randomized traffic.
module tb_mem_rmw_adapter;
  localparam int AW = 13;
  localparam int DW = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_rmw_adapter_if #(.AddrWidth(AW), .DataWidth(DW)) bus ();
  mem_rmw_adapter #(.AddrWidth(AW), .DataWidth(DW)) dut (
    .clk_i(clk), .rst_i(rst), .bus(bus)
  );

  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] sram_rdata_r = '0;
  always @(posedge clk) begin
    if (bus.sram_req_o) begin
      if (bus.sram_we_o) mem[bus.sram_addr_o] <= bus.sram_wdata_o;
      else               sram_rdata_r <= mem[bus.sram_addr_o];
    end
  end
  assign bus.sram_rdata_i = sram_rdata_r;

  int checks = 0;
  int failures = 0;

  task automatic check(input bit ok, input string name,
                       input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- request-level reference model ----------------
  typedef struct { int cyc; logic [63:0] data; } rsp_t;
  rsp_t exp_q[$];
  logic [63:0] ref_mem [0:(1<<AW)-1];
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  bit blocked = 0;
  bit after_rmw = 0;
  logic [AW-1:0] pend_addr = '0;
  logic [63:0] pend_old = '0;
  int rsp_cnt = 0;
  int sram_wr_cnt = 0;
  int sram_rd_cnt = 0;
  logic [63:0] last_rdata = '0;

  always @(negedge clk) begin
    rsp_t r;
    logic [63:0] m;
    bit partial;
    if (bus.sram_req_o) begin
      if (bus.sram_we_o) sram_wr_cnt++;
      else               sram_rd_cnt++;
    end
    if (rst) begin
      check(bus.gnt_o == 1'b0, "rst_gnt", 64'(bus.gnt_o), 0);
      check(bus.rvalid_o == 1'b0, "rst_rvalid", 64'(bus.rvalid_o), 0);
      check(bus.sram_req_o == 1'b0, "rst_sram_req", 64'(bus.sram_req_o), 0);
      check(bus.busy_o == 1'b0, "rst_busy", 64'(bus.busy_o), 0);
      if (blocked) ref_mem[pend_addr] = pend_old;  // aborted partial write
      exp_q.delete();
      blocked = 0;
      after_rmw = 0;
    end else begin
      if (bus.rvalid_o) begin
        rsp_cnt++;
        last_rdata = bus.rdata_o;
        if (exp_q.size() == 0) check(1'b0, "rvalid_unexpected", 1, 0);
        else begin
          r = exp_q.pop_front();
          check(cyc == r.cyc, "rsp_cycle", 64'(cyc), 64'(r.cyc));
          check(bus.rdata_o == r.data, "rsp_data", bus.rdata_o, r.data);
        end
      end else if (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
        check(1'b0, "rsp_missing", 0, 1);
        void'(exp_q.pop_front());
      end
      check(bus.gnt_o == (bus.req_i && !blocked), "gnt", 64'(bus.gnt_o),
            64'(bus.req_i && !blocked));
      check(bus.busy_o == (blocked || after_rmw), "busy", 64'(bus.busy_o),
            64'(blocked || after_rmw));
      partial = 0;
      if (bus.gnt_o) begin
        if (!bus.we_i) begin
          exp_q.push_back('{cyc + 1, ref_mem[bus.addr_i]});
        end else begin
          m = ref_mem[bus.addr_i];
          for (int k = 0; k < 8; k++)
            if (bus.strb_i[k]) m[8*k +: 8] = bus.wdata_i[8*k +: 8];
          partial = (bus.strb_i != 8'h00) && (bus.strb_i != 8'hFF);
          if (partial) begin
            pend_addr = bus.addr_i;
            pend_old  = ref_mem[bus.addr_i];
          end
          if (bus.strb_i == 8'h00)
            check(bus.sram_req_o == 1'b0, "zero_strb_access", 64'(bus.sram_req_o), 0);
          ref_mem[bus.addr_i] = m;
          exp_q.push_back('{cyc + (partial ? 2 : 1), 64'h0});
        end
      end
      after_rmw = blocked;
      blocked = bus.gnt_o && partial;
    end
  end

  // ---------------- driver helpers ----------------
  task automatic drive(input bit we, input logic [AW-1:0] a,
                       input logic [63:0] d, input logic [7:0] s);
    bus.req_i = 1'b1; bus.we_i = we; bus.addr_i = a; bus.wdata_i = d; bus.strb_i = s;
  endtask

  task automatic idle();
    bus.req_i = 1'b0; bus.we_i = 1'b0; bus.addr_i = '0; bus.wdata_i = '0; bus.strb_i = '0;
  endtask

  task automatic wait_gnt();
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.gnt_o) return;
      @(posedge clk); #1;
    end
    check(1'b0, "gnt_timeout", 0, 1);
  endtask

  task automatic single(input bit we, input logic [AW-1:0] a, input logic [63:0] d,
                        input logic [7:0] s, output int lat, output logic [63:0] rd);
    @(posedge clk); #1;
    drive(we, a, d, s);
    wait_gnt();
    @(posedge clk); #1;
    idle();
    lat = 0; rd = '0;
    for (int n = 1; n <= 4; n++) begin
      if (n > 1) begin @(posedge clk); #1; end
      @(negedge clk);
      if (bus.rvalid_o) begin lat = n; rd = bus.rdata_o; break; end
    end
  endtask

  typedef struct { bit we; logic [AW-1:0] addr; logic [63:0] data; logic [7:0] strb; } req_t;

  task automatic run_stream(input req_t rq[$], input bit gaps);
    foreach (rq[i]) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        @(posedge clk); #1; idle();
      end
      @(posedge clk); #1;
      drive(rq[i].we, rq[i].addr, rq[i].data, rq[i].strb);
      wait_gnt();
    end
    @(posedge clk); #1;
    idle();
  endtask

  typedef struct {
    string name; bit we; logic [AW-1:0] addr; logic [63:0] data; logic [7:0] strb;
    logic [63:0] exp_rdata; int exp_lat; int exp_wr; int exp_rd;
  } vec_t;
  vec_t vecs[11];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : main
    int lat, wr0, rd0, rsp0;
    logic [63:0] rd;
    req_t rq[$];
    logic [AW-1:0] chk_addrs[$];

    vecs[0]  = '{"preload_010",  1, 13'h010, 64'h1122334455667788, 8'hFF, 64'h0, 1, 1, 0};
    vecs[1]  = '{"read_010",     0, 13'h010, 64'h0,                8'h00, 64'h1122334455667788, 1, 0, 1};
    vecs[2]  = '{"full_wr_020",  1, 13'h020, 64'hDEADBEEFCAFEF00D, 8'hFF, 64'h0, 1, 1, 0};
    vecs[3]  = '{"read_020",     0, 13'h020, 64'h0,                8'h00, 64'hDEADBEEFCAFEF00D, 1, 0, 1};
    vecs[4]  = '{"preload_030",  1, 13'h030, 64'hAAAAAAAAAAAAAAAA, 8'hFF, 64'h0, 1, 1, 0};
    vecs[5]  = '{"partial_0F",   1, 13'h030, 64'h0000000012345678, 8'h0F, 64'h0, 2, 1, 1};
    vecs[6]  = '{"read_merged",  0, 13'h030, 64'h0,                8'h00, 64'hAAAAAAAA12345678, 1, 0, 1};
    vecs[7]  = '{"zero_strb",    1, 13'h030, 64'hFFFFFFFFFFFFFFFF, 8'h00, 64'h0, 1, 0, 0};
    vecs[8]  = '{"read_unchgd",  0, 13'h030, 64'h0,                8'h00, 64'hAAAAAAAA12345678, 1, 0, 1};
    vecs[9]  = '{"partial_81",   1, 13'h030, 64'h5500000000000066, 8'h81, 64'h0, 2, 1, 1};
    vecs[10] = '{"read_81",      0, 13'h030, 64'h0,                8'h00, 64'h55AAAAAA12345666, 1, 0, 1};

    idle();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    drive(1'b1, 13'h000, 64'h0, 8'hFF);
    @(negedge clk);
    check(bus.gnt_o == 1'b1, "first_after_reset", 64'(bus.gnt_o), 1);
    @(posedge clk); #1;
    idle();

    // Every address touched later holds a known value.
    rq.delete();
    for (int a = 1; a < 8; a++) rq.push_back('{1'b1, AW'(a), {$urandom, $urandom}, 8'hFF});
    rq.push_back('{1'b1, 13'h040, 64'h0123456789ABCDEF, 8'hFF});
    rq.push_back('{1'b1, 13'h050, 64'h1111111111111111, 8'hFF});
    run_stream(rq, 1'b0);
    repeat (3) @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      wr0 = sram_wr_cnt; rd0 = sram_rd_cnt;
      single(vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].strb, lat, rd);
      @(posedge clk); #1;
      check(lat == vecs[i].exp_lat, {vecs[i].name, "_lat"}, 64'(lat), 64'(vecs[i].exp_lat));
      check(rd == vecs[i].exp_rdata, {vecs[i].name, "_rdata"}, rd, vecs[i].exp_rdata);
      check(sram_wr_cnt - wr0 == vecs[i].exp_wr, {vecs[i].name, "_sram_wr"},
            64'(sram_wr_cnt - wr0), 64'(vecs[i].exp_wr));
      check(sram_rd_cnt - rd0 == vecs[i].exp_rd, {vecs[i].name, "_sram_rd"},
            64'(sram_rd_cnt - rd0), 64'(vecs[i].exp_rd));
    end

    // Back-to-back read / partial write / read on one address.
    rsp0 = rsp_cnt;
    rq.delete();
    rq.push_back('{1'b0, 13'h040, 64'h0, 8'h00});
    rq.push_back('{1'b1, 13'h040, 64'hFFEEDDCC00000000, 8'hF0});
    rq.push_back('{1'b0, 13'h040, 64'h0, 8'h00});
    run_stream(rq, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    check(rsp_cnt - rsp0 == 3, "b2b_rsp_count", 64'(rsp_cnt - rsp0), 3);
    check(last_rdata == 64'hFFEEDDCC89ABCDEF, "b2b_last_read", last_rdata, 64'hFFEEDDCC89ABCDEF);

    // Reset while the merged write is due.
    wr0 = sram_wr_cnt; rsp0 = rsp_cnt;
    @(posedge clk); #1;
    drive(1'b1, 13'h050, 64'h00000000000000FF, 8'h01);
    @(negedge clk);
    check(bus.gnt_o == 1'b1, "abort_gnt", 64'(bus.gnt_o), 1);
    @(posedge clk); #1;
    idle();
    rst = 1'b1;
    @(negedge clk);
    check(bus.sram_we_o == 1'b0, "abort_no_write", 64'(bus.sram_we_o), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check(bus.busy_o == 1'b0, "abort_busy", 64'(bus.busy_o), 0);
    check(bus.rvalid_o == 1'b0, "abort_rvalid", 64'(bus.rvalid_o), 0);
    repeat (3) @(posedge clk);
    #1;
    check(sram_wr_cnt == wr0, "abort_wr_count", 64'(sram_wr_cnt - wr0), 0);
    check(rsp_cnt == rsp0, "abort_rsp_count", 64'(rsp_cnt - rsp0), 0);
    single(1'b0, 13'h050, 64'h0, 8'h00, lat, rd);
    check(rd == 64'h1111111111111111, "abort_mem_kept", rd, 64'h1111111111111111);

    // Randomized traffic over a small address window to provoke hazards.
    rq.delete();
    for (int i = 0; i < 300; i++) begin
      req_t t;
      int kind;
      kind = $urandom_range(0, 3);
      t.addr = AW'($urandom_range(0, 7));
      t.data = {$urandom, $urandom};
      t.we = (kind != 0);
      case (kind)
        0: t.strb = 8'h00;
        1: t.strb = 8'hFF;
        2: t.strb = 8'h00;
        default: begin
          t.strb = 8'($urandom);
          if (t.strb == 8'h00 || t.strb == 8'hFF) t.strb = 8'h3C;
        end
      endcase
      rq.push_back(t);
    end
    run_stream(rq, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    check(exp_q.size() == 0, "drain_pending", 64'(exp_q.size()), 0);

    for (int a = 0; a < 8; a++) chk_addrs.push_back(AW'(a));
    chk_addrs.push_back(13'h010); chk_addrs.push_back(13'h020); chk_addrs.push_back(13'h030);
    chk_addrs.push_back(13'h040); chk_addrs.push_back(13'h050);
    foreach (chk_addrs[i])
      check(mem[chk_addrs[i]] == ref_mem[chk_addrs[i]], "final_mem",
            mem[chk_addrs[i]], ref_mem[chk_addrs[i]]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
